// File: rtl/ptl_pkg.sv
// Shared PTL link constants. The delay and critical time match the receiver cell model.
package ptl_pkg;

  localparam int unsigned PTL_DELAY_CYC   = 5;
  localparam int unsigned PTL_HOLDOFF_CYC = 11;
  localparam int unsigned PTL_DEPTH       = 4;
  localparam int unsigned PTL_CNT_W       = 3;

  typedef logic [PTL_CNT_W-1:0] ptl_pend_t;

endpackage

// File: rtl/ptl_launch_delay.sv
// Launch delay line: a launch pulse walks a DELAY_CYC-deep shift register.
// When the pulse leaves the last stage, it toggles the registered PTL drive q.
module ptl_launch_delay #(
  parameter int unsigned DELAY_CYC = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  output logic q,
  output logic in_flight
);

  logic [DELAY_CYC-1:0] sr_q, sr_d;
  logic                 q_q;

  if (DELAY_CYC == 1) begin : g_one
    assign sr_d = launch;
  end else begin : g_multi
    assign sr_d = {sr_q[DELAY_CYC-2:0], launch};
  end

  // Shift launches toward the output; toggle q as each one falls off the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
      q_q  <= 1'b0;
    end else begin
      sr_q <= sr_d;
      q_q  <= q_q ^ sr_q[DELAY_CYC-1];
    end
  end

  assign q         = q_q;
  assign in_flight = |sr_q;

endmodule

// File: rtl/ptltx_pulse_scheduler.sv
// PTL transmitter: accepts toggle-encoded pulses and spaces their launches by at least
// HOLDOFF_CYC. Pending pulses are buffered in a counter, and q is driven after DELAY_CYC.
module ptltx_pulse_scheduler
  import ptl_pkg::*;
#(
  parameter int unsigned DELAY_CYC   = PTL_DELAY_CYC,
  parameter int unsigned HOLDOFF_CYC = PTL_HOLDOFF_CYC,
  parameter int unsigned DEPTH       = PTL_DEPTH,
  parameter int unsigned CNT_W       = PTL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  output logic             q,
  output logic             busy,
  output logic [CNT_W-1:0] pend,
  output logic             err
);

  // Sized so that HOLDOFF_CYC == 1 still gets a one-bit timer.
  localparam int unsigned HO_W = $clog2(HOLDOFF_CYC + 1);

  localparam logic [CNT_W-1:0] DepthVal   = CNT_W'(DEPTH);
  localparam logic [HO_W-1:0]  HoldReload = HO_W'(HOLDOFF_CYC - 1);

  logic             a_dly_q;
  logic [HO_W-1:0]  holdoff_q, holdoff_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             accept, launch, overflow, in_flight;

  // Edge detect, launch decision, pending count, holdoff timer and sticky overflow flag.
  always_comb begin
    accept   = a ^ a_dly_q;
    launch   = ((pend_q != '0) || accept) && (holdoff_q == '0);
    // Launching on the same edge frees a slot, so a full counter can still take the pulse.
    overflow = accept && (pend_q == DepthVal) && !launch;

    pend_d = pend_q;
    if (accept && !overflow && !launch) begin
      pend_d = pend_q + CNT_W'(1);
    end else if (launch && !accept) begin
      pend_d = pend_q - CNT_W'(1);
    end

    holdoff_d = holdoff_q;
    if (launch) begin
      holdoff_d = HoldReload;
    end else if (holdoff_q != '0) begin
      holdoff_d = holdoff_q - HO_W'(1);
    end

    err_d = err_q | overflow;
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dly_q   <= 1'b0;
      holdoff_q <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      a_dly_q   <= a;
      holdoff_q <= holdoff_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  ptl_launch_delay #(
    .DELAY_CYC (DELAY_CYC)
  ) u_launch_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .launch    (launch),
    .q         (q),
    .in_flight (in_flight)
  );

  assign busy = (pend_q != '0) | in_flight;
  assign pend = pend_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ptltx_pulse_scheduler.sv
// Directed bench for ptltx_pulse_scheduler with default parameters.
// Each table row sets a for edge edge_n (counted from reset release) and gives the outputs
// expected just after that edge. Between rows, a holds its value.
module tb_ptltx_pulse_scheduler;
  import ptl_pkg::*;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  logic      a     = 1'b0;
  logic      q, busy, err;
  ptl_pend_t pend;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  ptltx_pulse_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .q     (q),
    .busy  (busy),
    .pend  (pend),
    .err   (err)
  );

  typedef struct {
    int unsigned edge_n;
    logic        a;
    logic        q;
    logic        busy;
    ptl_pend_t   pend;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int unsigned e, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0d, expected %0d", name, e, act, exp);
    end
  endtask

  task automatic add(input int unsigned e, input logic a_v, input logic q_v, input logic b_v,
                     input int unsigned p_v, input logic e_v);
    vec_t t;
    t.edge_n = e;
    t.a      = a_v;
    t.q      = q_v;
    t.busy   = b_v;
    t.pend   = ptl_pend_t'(p_v);
    t.err    = e_v;
    vecs.push_back(t);
  endtask

  // Assert reset between edges, check the asynchronous clear, then release after two cycles.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    a     = 1'b0;
    #1;
    chk({name, "_rst_q"}, 0, 32'(q), 0);
    chk({name, "_rst_busy"}, 0, 32'(busy), 0);
    chk({name, "_rst_pend"}, 0, 32'(pend), 0);
    chk({name, "_rst_err"}, 0, 32'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply the table edge by edge, starting at edge 1 after release, and count q toggles.
  task automatic run(input string name, input int unsigned exp_toggles);
    int          idx = 0;
    int unsigned toggles = 0;
    int unsigned last;
    logic        q_prev;
    last   = vecs[vecs.size()-1].edge_n;
    q_prev = q;
    for (int unsigned e = 1; e <= last; e++) begin
      if (vecs[idx].edge_n == e) a = vecs[idx].a;
      @(posedge clk);
      #1;
      if (q !== q_prev) toggles++;
      q_prev = q;
      if (vecs[idx].edge_n == e) begin
        chk({name, "_q"}, e, 32'(q), 32'(vecs[idx].q));
        chk({name, "_busy"}, e, 32'(busy), 32'(vecs[idx].busy));
        chk({name, "_pend"}, e, 32'(pend), 32'(vecs[idx].pend));
        chk({name, "_err"}, e, 32'(err), 32'(vecs[idx].err));
        idx++;
      end
    end
    chk({name, "_toggles"}, last, toggles, exp_toggles);
    vecs.delete();
  endtask

  initial begin
    // Single pulse: accepted and launched at 10, q toggles at 15.
    do_reset("single");
    add(1, 0, 0, 0, 0, 0);   add(9, 0, 0, 0, 0, 0);   add(10, 1, 0, 1, 0, 0);
    add(14, 1, 0, 1, 0, 0);  add(15, 1, 1, 0, 0, 0);  add(20, 1, 1, 0, 0, 0);
    run("single", 1);

    // Spacing: accepts at 10 and 13, launches at 10 and 21.
    do_reset("spacing");
    add(1, 0, 0, 0, 0, 0);   add(10, 1, 0, 1, 0, 0);  add(13, 0, 0, 1, 1, 0);
    add(15, 0, 1, 1, 1, 0);  add(20, 0, 1, 1, 1, 0);  add(21, 0, 1, 1, 0, 0);
    add(25, 0, 1, 1, 0, 0);  add(26, 0, 0, 0, 0, 0);  add(30, 0, 0, 0, 0, 0);
    run("spacing", 2);

    // Overflow: six accepts on edges 10..15; the one at 15 is dropped.
    do_reset("ovf");
    add(10, 1, 0, 1, 0, 0);  add(11, 0, 0, 1, 1, 0);  add(12, 1, 0, 1, 2, 0);
    add(13, 0, 0, 1, 3, 0);  add(14, 1, 0, 1, 4, 0);  add(15, 0, 1, 1, 4, 1);
    add(20, 0, 1, 1, 4, 1);  add(21, 0, 1, 1, 3, 1);  add(26, 0, 0, 1, 3, 1);
    add(32, 0, 0, 1, 2, 1);  add(37, 0, 1, 1, 2, 1);  add(54, 0, 0, 1, 0, 1);
    add(59, 0, 1, 0, 0, 1);  add(65, 0, 1, 0, 0, 1);
    run("ovf", 5);

    // Full plus simultaneous launch. Five accepts on edges 10..14 fill the counter to 4.
    // A sixth accept lands on launch edge 21, so pend stays 4 and there is no error.
    // All six pulses are kept, giving q toggles at 15, 26, 37, 48, 59 and 70.
    do_reset("fullsim");
    add(1, 0, 0, 0, 0, 0);   add(10, 1, 0, 1, 0, 0);  add(11, 0, 0, 1, 1, 0);
    add(12, 1, 0, 1, 2, 0);  add(13, 0, 0, 1, 3, 0);  add(14, 1, 0, 1, 4, 0);
    add(15, 1, 1, 1, 4, 0);  add(20, 1, 1, 1, 4, 0);  add(21, 0, 1, 1, 4, 0);
    add(26, 0, 0, 1, 4, 0);  add(32, 0, 0, 1, 3, 0);  add(65, 0, 1, 1, 0, 0);
    add(70, 0, 0, 0, 0, 0);  add(75, 0, 0, 0, 0, 0);
    run("fullsim", 6);

    // Reset mid-flight: accept at 10, reset between edges 12 and 13, no toggle afterwards.
    do_reset("mid_pre");
    add(1, 0, 0, 0, 0, 0);   add(10, 1, 0, 1, 0, 0);  add(12, 1, 0, 1, 0, 0);
    run("mid_a", 0);
    do_reset("mid");
    add(1, 0, 0, 0, 0, 0);   add(5, 0, 0, 0, 0, 0);   add(20, 0, 0, 0, 0, 0);
    run("mid_b", 0);

    // Back-to-back, exactly holdoff-spaced: every pulse launches at once.
    do_reset("b2b");
    add(1, 0, 0, 0, 0, 0);   add(10, 1, 0, 1, 0, 0);  add(15, 1, 1, 0, 0, 0);
    add(21, 0, 1, 1, 0, 0);  add(26, 0, 0, 0, 0, 0);  add(32, 1, 0, 1, 0, 0);
    add(37, 1, 1, 0, 0, 0);  add(40, 1, 1, 0, 0, 0);
    run("b2b", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
